// File: rtl/sitcpxg_tx_arbiter_if.sv
// Bundle of the requester-side and core-side signals of the SiTCPXG TX arbiter.
// The slave modport is the arbiter's view, the master modport is the user/core side.
interface sitcpxg_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic                SiTCPXG_ESTABLISHED;
    logic                SiTCPXG_TX_AFULL;
    logic [N_REQ-1:0]    REQ;
    logic [N_REQ-1:0]    GNT;
    logic [64*N_REQ-1:0] REQ_TX_D;
    logic [4*N_REQ-1:0]  REQ_TX_B;
    logic [63:0]         SiTCPXG_TX_D;
    logic [3:0]          SiTCPXG_TX_B;
    logic [32*N_REQ-1:0] BYTE_CNT;
    logic                LEN_ERR;

    modport slave (
        input  SiTCPXG_ESTABLISHED, SiTCPXG_TX_AFULL, REQ, REQ_TX_D, REQ_TX_B,
        output GNT, SiTCPXG_TX_D, SiTCPXG_TX_B, BYTE_CNT, LEN_ERR
    );

    modport master (
        output SiTCPXG_ESTABLISHED, SiTCPXG_TX_AFULL, REQ, REQ_TX_D, REQ_TX_B,
        input  GNT, SiTCPXG_TX_D, SiTCPXG_TX_B, BYTE_CNT, LEN_ERR
    );
endinterface

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin arbiter sharing the SiTCPXG TX stream between N_REQ sources,
// with a per-grant byte quantum and AFULL / session gating of the grant.
module sitcpxg_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int QUANTUM = 16384
) (
    input  logic                 CLK156M,
    input  logic                 RSTs,
    sitcpxg_tx_arbiter_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   cur_q, cur_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [17:0]        qcnt_q, qcnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               est_q, afull_q;
    logic [63:0]        tx_d_q;
    logic [3:0]         tx_b_q;
    logic [31:0]        byte_cnt_q [N_REQ];
    logic               len_err_q;

    logic [63:0]        req_d [N_REQ];
    logic [3:0]         req_b [N_REQ];
    logic [PTR_W-1:0]   rr_idx [N_REQ];
    logic [3:0]         cur_b;
    logic [18:0]        qsum;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               accept;
    logic               bad_len;
    logic               est_rise;

    // Unpack the flat requester buses; rr_idx[i] is the i-th candidate in round-robin order.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_d[gi]  = bus.REQ_TX_D[64*gi +: 64];
            assign req_b[gi]  = bus.REQ_TX_B[4*gi +: 4];
            assign rr_idx[gi] = PTR_W'((int'(rr_ptr_q) + gi) % N_REQ);
            assign bus.BYTE_CNT[32*gi +: 32] = byte_cnt_q[gi];
        end
    endgenerate

    assign cur_b    = req_b[cur_q];
    assign accept   = gnt_q[cur_q] && (cur_b != 4'd0) && (cur_b <= 4'd8);
    assign bad_len  = gnt_q[cur_q] && (cur_b > 4'd8);
    assign qsum     = {1'b0, qcnt_q} + 19'(cur_b);
    assign next_ptr = (cur_q == PTR_W'(N_REQ - 1)) ? '0 : cur_q + 1'b1;
    assign est_rise = bus.SiTCPXG_ESTABLISHED && !est_q;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && bus.REQ[rr_idx[i]]) begin
                pick_found = 1'b1;
                pick_idx   = rr_idx[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        qcnt_d   = qcnt_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = '0;
        if (!est_q) begin
            state_d = IDLE;
            qcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_d = GRANT;
                        cur_d   = pick_idx;
                        qcnt_d  = '0;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        qcnt_d = qsum[17:0];
                    end
                    // The word that crosses the quantum is still forwarded; rotation follows it.
                    if (!bus.REQ[cur_q] || (accept && (qsum >= 19'(QUANTUM)))) begin
                        state_d  = GAP;
                        rr_ptr_d = next_ptr;
                    end
                end
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if ((state_d == GRANT) && !afull_q && est_q) begin
            gnt_d[cur_d] = 1'b1;
        end
    end

    always_ff @(posedge CLK156M) begin
        if (RSTs) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            rr_ptr_q  <= '0;
            qcnt_q    <= '0;
            gnt_q     <= '0;
            est_q     <= 1'b0;
            afull_q   <= 1'b0;
            tx_d_q    <= '0;
            tx_b_q    <= '0;
            len_err_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                byte_cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            qcnt_q   <= qcnt_d;
            gnt_q    <= gnt_d;
            est_q    <= bus.SiTCPXG_ESTABLISHED;
            afull_q  <= bus.SiTCPXG_TX_AFULL;
            if (accept) begin
                tx_d_q <= req_d[cur_q];
                tx_b_q <= cur_b;
            end else begin
                tx_b_q <= '0;
            end
            if (bad_len) begin
                len_err_q <= 1'b1;
            end
            // Counters restart with every new session.
            for (int i = 0; i < N_REQ; i++) begin
                if (est_rise) begin
                    byte_cnt_q[i] <= '0;
                end else if (accept && (cur_q == PTR_W'(i))) begin
                    byte_cnt_q[i] <= byte_cnt_q[i] + 32'(cur_b);
                end
            end
        end
    end

    assign bus.GNT          = gnt_q;
    assign bus.SiTCPXG_TX_D = tx_d_q;
    assign bus.SiTCPXG_TX_B = tx_b_q;
    assign bus.LEN_ERR      = len_err_q;

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// Directed bench for sitcpxg_tx_arbiter: requester models react to GNT, a monitor
// checks every forwarded word one cycle after acceptance, scenarios check grant patterns.
module tb_sitcpxg_tx_arbiter;
    localparam int N       = 4;
    localparam int QUANTUM = 64;

    logic clk;
    logic srst;

    sitcpxg_tx_arbiter_if #(.N_REQ(N)) bus ();

    sitcpxg_tx_arbiter #(.N_REQ(N), .QUANTUM(QUANTUM)) dut (
        .CLK156M (clk),
        .RSTs    (srst),
        .bus     (bus)
    );

    int cmp_cnt = 0;
    int mis_cnt = 0;

    int           n_words  [N];
    int           word_b   [N];
    int           next_idx [N];
    int           out_cnt  [N];
    logic [N-1:0] gnt_prev;
    logic [3:0]   b_prev   [N];
    int           lat_err    = 0;
    int           order_err  = 0;
    int           onehot_err = 0;
    int           cyc        = 0;
    int           zero_run   = 0;
    bit           gnt_trace [8192];
    int           grant_seq[$];
    int           grant_words[$];
    int           gap_seq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] word_data(input int n, input int i);
        return {8'(n), 8'hA5, 16'h0000, 32'(i)};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic bit all_done();
        for (int n = 0; n < N; n++) begin
            if (next_idx[n] < n_words[n]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic setup(input int w0, input int b0, input int w1, input int b1);
        for (int n = 0; n < N; n++) begin
            n_words[n]  = 0;
            word_b[n]   = 0;
            next_idx[n] = 0;
            out_cnt[n]  = 0;
        end
        n_words[0] = w0;
        word_b[0]  = b0;
        n_words[1] = w1;
        word_b[1]  = b1;
        lat_err    = 0;
        order_err  = 0;
        grant_seq.delete();
        grant_words.delete();
        gap_seq.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        while (!all_done() && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_val({tag, "_done"}, 64'(all_done()), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    // Requester models and output monitor, evaluated 1 time unit after each rising edge.
    initial begin
        logic [N-1:0] g;
        logic         exp_v;
        logic [63:0]  exp_d;
        logic [3:0]   exp_b;
        int           tag;
        int           gidx;
        bus.REQ      = '0;
        bus.REQ_TX_D = '0;
        bus.REQ_TX_B = '0;
        gnt_prev     = '0;
        for (int n = 0; n < N; n++) b_prev[n] = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            exp_v = 1'b0;
            exp_d = '0;
            exp_b = '0;
            if (!srst) begin
                for (int n = 0; n < N; n++) begin
                    if (gnt_prev[n] && (b_prev[n] >= 4'd1) && (b_prev[n] <= 4'd8)) begin
                        exp_v = 1'b1;
                        exp_d = word_data(n, next_idx[n]);
                        exp_b = b_prev[n];
                        next_idx[n]++;
                        if (grant_words.size() > 0)
                            grant_words[grant_words.size()-1] = grant_words[grant_words.size()-1] + 1;
                    end
                end
                if (exp_v) begin
                    if (bus.SiTCPXG_TX_B !== exp_b || bus.SiTCPXG_TX_D !== exp_d) lat_err++;
                end else if (bus.SiTCPXG_TX_B !== 4'd0) begin
                    lat_err++;
                end
                if (bus.SiTCPXG_TX_B != 4'd0) begin
                    tag = int'(bus.SiTCPXG_TX_D[63:56]);
                    if (tag < N) begin
                        if (bus.SiTCPXG_TX_D == word_data(tag, out_cnt[tag])) out_cnt[tag]++;
                        else order_err++;
                    end else begin
                        order_err++;
                    end
                end
            end
            g = bus.GNT;
            if ($countones(g) > 1) onehot_err++;
            if (g != '0 && gnt_prev == '0) begin
                gidx = 0;
                for (int n = 0; n < N; n++) if (g[n]) gidx = n;
                grant_seq.push_back(gidx);
                gap_seq.push_back(zero_run);
                grant_words.push_back(0);
            end
            zero_run = (g == '0) ? zero_run + 1 : 0;
            if (cyc < 8192) gnt_trace[cyc] = g[0];
            for (int n = 0; n < N; n++) begin
                if (next_idx[n] < n_words[n]) begin
                    bus.REQ[n]              = 1'b1;
                    bus.REQ_TX_D[64*n +: 64] = word_data(n, next_idx[n]);
                    bus.REQ_TX_B[4*n +: 4]   = 4'(word_b[n]);
                end else begin
                    bus.REQ[n]              = 1'b0;
                    bus.REQ_TX_D[64*n +: 64] = '0;
                    bus.REQ_TX_B[4*n +: 4]   = 4'd0;
                end
                b_prev[n] = bus.REQ_TX_B[4*n +: 4];
            end
            gnt_prev = g;
        end
    end

    initial begin
        int k;
        int c;
        int zeros;
        int exp_seq [6];
        srst = 1'b1;
        bus.SiTCPXG_ESTABLISHED = 1'b1;
        bus.SiTCPXG_TX_AFULL    = 1'b0;
        setup(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_gnt",     64'(bus.GNT), 64'd0);
        check_val("rst_tx_b",    64'(bus.SiTCPXG_TX_B), 64'd0);
        check_val("rst_tx_d",    bus.SiTCPXG_TX_D, 64'd0);
        check_val("rst_len_err", 64'(bus.LEN_ERR), 64'd0);
        check_val("rst_bytecnt", 64'(bus.BYTE_CNT), 64'd0);
        srst = 1'b0;

        // Single requester, 20 x 8 bytes: rotates through GAP every 64 bytes and is re-granted.
        apply_reset();
        setup(20, 8, 0, 0);
        wait_done("s1", 300);
        check_val("s1_words",   64'(out_cnt[0]), 64'd20);
        check_val("s1_latency", 64'(lat_err), 64'd0);
        check_val("s1_order",   64'(order_err), 64'd0);
        check_val("s1_bytecnt", 64'(bus.BYTE_CNT[31:0]), 64'd160);
        check_val("s1_ngrants", 64'(grant_seq.size()), 64'd3);
        check_val("s1_g0_words", 64'((grant_words.size() > 0) ? grant_words[0] : -1), 64'd8);
        check_val("s1_g2_words", 64'((grant_words.size() > 2) ? grant_words[2] : -1), 64'd4);

        // Two steady requesters: 0,1,0,1,0,1 with 8 words each, GNT low for GAP + IDLE cycle.
        apply_reset();
        setup(24, 8, 24, 8);
        wait_done("s2", 400);
        exp_seq = '{0, 1, 0, 1, 0, 1};
        check_val("s2_ngrants", 64'(grant_seq.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("s2_gnt%0d_idx", i),
                      64'((i < grant_seq.size()) ? grant_seq[i] : -1), 64'(exp_seq[i]));
            check_val($sformatf("s2_gnt%0d_words", i),
                      64'((i < grant_words.size()) ? grant_words[i] : -1), 64'd8);
            if (i > 0)
                check_val($sformatf("s2_gap%0d", i),
                          64'((i < gap_seq.size()) ? gap_seq[i] : -1), 64'd2);
        end
        check_val("s2_bytecnt0", 64'(bus.BYTE_CNT[31:0]), 64'd192);
        check_val("s2_bytecnt1", 64'(bus.BYTE_CNT[63:32]), 64'd192);
        check_val("s2_latency",  64'(lat_err + order_err), 64'd0);

        // 7-byte words against a 64-byte quantum: 9 words = 63, 10th word reaches 70 and ends the grant.
        apply_reset();
        setup(12, 7, 0, 0);
        wait_done("s3", 300);
        check_val("s3_g0_words", 64'((grant_words.size() > 0) ? grant_words[0] : -1), 64'd10);
        check_val("s3_g1_words", 64'((grant_words.size() > 1) ? grant_words[1] : -1), 64'd2);
        check_val("s3_bytecnt",  64'(bus.BYTE_CNT[31:0]), 64'd84);
        check_val("s3_latency",  64'(lat_err + order_err), 64'd0);

        // AFULL high for 5 sampled cycles mid-grant: GNT low for exactly 5 cycles, 2 cycles later.
        apply_reset();
        setup(10, 4, 0, 0);
        c = 0;
        while (next_idx[0] < 3 && c < 100) begin
            @(negedge clk);
            c++;
        end
        k = cyc;
        bus.SiTCPXG_TX_AFULL = 1'b1;
        repeat (5) @(negedge clk);
        bus.SiTCPXG_TX_AFULL = 1'b0;
        wait_done("s4", 300);
        zeros = 0;
        for (int i = k + 2; i <= k + 6; i++) if (!gnt_trace[i]) zeros++;
        check_val("s4_gnt_before", 64'(gnt_trace[k+1]), 64'd1);
        check_val("s4_gnt_low5",   64'(zeros), 64'd5);
        check_val("s4_gnt_after",  64'(gnt_trace[k+7]), 64'd1);
        check_val("s4_words",      64'(out_cnt[0]), 64'd10);
        check_val("s4_bytecnt",    64'(bus.BYTE_CNT[31:0]), 64'd40);
        check_val("s4_latency",    64'(lat_err + order_err), 64'd0);

        // Session drop mid-grant: GNT gone within 2 cycles, counters clear on re-establish,
        // grant resumes at the unchanged round-robin pointer (requester 0).
        apply_reset();
        setup(20, 2, 4, 2);
        c = 0;
        while (next_idx[0] < 4 && c < 100) begin
            @(negedge clk);
            c++;
        end
        k = cyc;
        bus.SiTCPXG_ESTABLISHED = 1'b0;
        repeat (5) @(negedge clk);
        check_val("s5_bytes_held", 64'(bus.BYTE_CNT[31:0]), 64'(2 * next_idx[0]));
        bus.SiTCPXG_ESTABLISHED = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_val("s5_bytecnt_clr", 64'(bus.BYTE_CNT[63:0]), 64'd0);
        wait_done("s5", 300);
        check_val("s5_gnt_drop", 64'(gnt_trace[k+2]), 64'd0);
        check_val("s5_resume0",  64'((grant_seq.size() > 1) ? grant_seq[1] : -1), 64'd0);
        check_val("s5_then1",    64'((grant_seq.size() > 2) ? grant_seq[2] : -1), 64'd1);
        check_val("s5_words0",   64'(out_cnt[0]), 64'd20);
        check_val("s5_words1",   64'(out_cnt[1]), 64'd4);
        check_val("s5_latency",  64'(lat_err + order_err), 64'd0);

        // Oversized words are dropped and latch LEN_ERR; reset mid-grant clears everything.
        apply_reset();
        setup(6, 9, 0, 0);
        repeat (6) @(negedge clk);
        check_val("s6_len_err",  64'(bus.LEN_ERR), 64'd1);
        check_val("s6_dropped",  64'(out_cnt[0]), 64'd0);
        check_val("s6_bytecnt",  64'(bus.BYTE_CNT[31:0]), 64'd0);
        check_val("s6_tx_idle",  64'(lat_err), 64'd0);
        word_b[0] = 8;
        repeat (3) @(negedge clk);
        check_val("s6_len_held", 64'(bus.LEN_ERR), 64'd1);
        check_val("s6_fwd",      64'(out_cnt[0] != 0), 64'd1);
        srst = 1'b1;
        @(negedge clk);
        check_val("s6_rst_gnt",     64'(bus.GNT), 64'd0);
        check_val("s6_rst_tx_b",    64'(bus.SiTCPXG_TX_B), 64'd0);
        check_val("s6_rst_tx_d",    bus.SiTCPXG_TX_D, 64'd0);
        check_val("s6_rst_len_err", 64'(bus.LEN_ERR), 64'd0);
        check_val("s6_rst_bytecnt", 64'(bus.BYTE_CNT), 64'd0);
        srst = 1'b0;
        setup(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("onehot", 64'(onehot_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
